// File: rtl/approx_mult_seq.sv
// Sequential leading-one approximate multiplier: normalise each operand, multiply
// the top KEEP bits, then shift the partial product back into the full result.
module approx_mult_seq #(
  parameter int WIDTH = 16,
  parameter int KEEP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int L  = WIDTH - KEEP;
  localparam int CW = (L < 1) ? 1 : $clog2(L + 1);
  localparam int SW = (L < 1) ? 1 : $clog2(2 * L + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NORM_A = 3'd1,
    S_NORM_B = 3'd2,
    S_MUL    = 3'd3,
    S_DENORM = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt_a;
  logic [CW-1:0]      r_cnt_b;
  logic [SW-1:0]      r_cnt_s;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_a_stop;
  logic               w_b_stop;
  logic [2*KEEP-1:0]  w_mul;
  logic [SW-1:0]      w_cnt_s_init;

  // Normalisation stops at the leading one or at the shift cap, which also covers a zero operand.
  assign w_a_stop     = r_a[WIDTH-1] | (r_cnt_a == CW'(L));
  assign w_b_stop     = r_b[WIDTH-1] | (r_cnt_b == CW'(L));
  assign w_mul        = (2*KEEP)'(r_a[WIDTH-1 -: KEEP]) * (2*KEEP)'(r_b[WIDTH-1 -: KEEP]);
  assign w_cnt_s_init = SW'(2 * L) - SW'(r_cnt_a) - SW'(r_cnt_b);

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

  // State and handshake output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_NORM_A;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NORM_A: begin
        if (w_a_stop) begin
          w_state_nxt = S_NORM_B;
        end else begin
          w_state_nxt = S_NORM_A;
        end
      end
      S_NORM_B: begin
        if (w_b_stop) begin
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_NORM_B;
        end
      end
      S_MUL: w_state_nxt = S_DENORM;
      S_DENORM: begin
        if (r_cnt_s == SW'(0)) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DENORM;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath: the shift counts always sum to 2L, which keeps the latency constant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_cnt_s   <= '0;
      r_prod    <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
          end
        end
        S_NORM_A: begin
          if (!w_a_stop) begin
            r_a     <= {r_a[WIDTH-2:0], 1'b0};
            r_cnt_a <= r_cnt_a + CW'(1);
          end
        end
        S_NORM_B: begin
          if (!w_b_stop) begin
            r_b     <= {r_b[WIDTH-2:0], 1'b0};
            r_cnt_b <= r_cnt_b + CW'(1);
          end
        end
        S_MUL: begin
          r_prod  <= (2*WIDTH)'(w_mul);
          r_cnt_s <= w_cnt_s_init;
        end
        S_DENORM: begin
          if (r_cnt_s == SW'(0)) begin
            r_product <= r_prod;
          end else begin
            r_prod  <= {r_prod[2*WIDTH-2:0], 1'b0};
            r_cnt_s <= r_cnt_s - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/approx_mult_seq.md
Name: approx_mult_seq

Overview:
- Parametrised sequential approximate multiplier for unsigned operands; a generalised successor to the fixed 16-bit/8-bit leading-one datapath.
- Each operand is left-normalised to its leading one, capped at WIDTH-KEEP shifts. The top KEEP bits of each operand are multiplied, and the product is shifted back into the 2*WIDTH result.
- Adds what the fixed datapath lacks: integrated controller, start/busy/done handshake, constant latency, exact results for small operands, and a held output register.

Parameters:
- WIDTH, 16, operand width in bits (>= 2).
- KEEP, 8, bits of each operand fed to the core multiplier (2 <= KEEP <= WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high from the accepting edge until DONE is entered.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result register; holds until the next DONE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, product=0.
  - All internal registers and counters are cleared.
  - Reset mid-operation aborts immediately; no done is produced.
- Let L = WIDTH-KEEP.
- Counters:
  - cntA and cntB range 0..L.
  - cntS ranges 0..2L.
  - Counter width is the minimal width able to hold the range, minimum 1 bit.
- IDLE: on start=1, regA<=a, regB<=b, cntA=cntB=0, go NORM_A, busy=1.
- NORM_A, one decision per cycle:
  - If regA[WIDTH-1]=1 or cntA==L, go NORM_B with no shift.
  - Otherwise regA<<=1 and cntA++.
  - Zero operand therefore stops at cntA==L.
- NORM_B: identical to NORM_A, using regB and cntB, then go MUL.
- MUL, single cycle:
  - prodReg <= zero-extended regA[WIDTH-1 -: KEEP] * regB[WIDTH-1 -: KEEP] (2*KEEP bits).
  - cntS <= 2L - cntA - cntB.
  - Go DENORM.
- DENORM:
  - If cntS==0, product<=prodReg and go DONE.
  - Otherwise prodReg<<=1 and cntS--.
  - No overflow is possible; the result always fits in 2*WIDTH bits.
- DONE: done=1 and busy=0 for exactly one cycle, then go IDLE.
- Handshake rules:
  - start is ignored in every state except IDLE, including DONE.
  - A new start may be accepted in the cycle immediately after DONE.
- Latency: constant.
  - done is high in the cycle after the (2L+4)th rising edge counted from the start-accepting edge (edge 0).
  - This gives 20 edges for 16/8 and 4 edges when KEEP=WIDTH.
- Accuracy:
  - Exact when a < 2^KEEP and b < 2^KEEP, or when either operand is 0.
  - Exact for all inputs when KEEP=WIDTH.
  - Otherwise the result is truncated: it is never above the exact product.
- Operands a and b may change freely after the accepting edge.

Test Plan:
- W16/K8: a=3, b=5, start pulse -> done after 20 edges, product=15 (exact); busy high throughout, low in the DONE cycle.
- W16/K8: a=16'hFFFF, b=16'hFFFF -> product=32'hFE010000 (exact value 32'hFFFE0001).
- W16/K8: a=16'h8000, b=16'h0100 -> product=32'h00800000 (exact); a=0, b=1234 -> product=0 with latency still 20.
- W16/K8: a=16'h1234, b=2 -> product=9280, below the exact 9320.
  - Re-assert start and change a while busy -> ignored; the result is unchanged.
  - product holds 9280 until the next DONE.
- Drop rst during DENORM -> busy, done and product go to 0 immediately with no done pulse.
  - Next start after reset release behaves normally.
- W8/K4: a=b=8'hFF -> done after 12 edges, product=16'hE100.
  - W8/K8: a=b=8'hFF -> product=16'hFE01 after 4 edges.
